// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// WIDTH-step shift-add multiply and restoring divide, with sign fix-up in a final cycle.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;      // product high half / partial remainder
    logic [WIDTH-1:0] r_q;        // multiplier bits / dividend bits then quotient
    logic [WIDTH-1:0] r_b;        // multiplicand / divisor magnitude
    logic             r_is_div;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic             r_zero_div;

    logic             w_signed_op;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_signed_op = ~op[0];
    assign w_a_neg     = w_signed_op & srcA[WIDTH-1];
    assign w_b_neg     = w_signed_op & srcB[WIDTH-1];
    assign w_a_mag     = w_a_neg ? -srcA : srcA;
    assign w_b_mag     = w_b_neg ? -srcB : srcB;

    assign w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : {(WIDTH + 1){1'b0}});
    assign w_rem_sh    = {r_acc, r_q[WIDTH-1]};
    assign w_diff      = w_rem_sh - {1'b0, r_b};

    assign w_prod      = {r_acc, r_q};
    assign w_prod_fix  = r_neg_res ? -w_prod : w_prod;
    // A zero divisor leaves the dividend in the remainder, so only the quotient is forced.
    assign w_quo_fix   = r_zero_div ? {WIDTH{1'b1}} : (r_neg_res ? -r_q : r_q);
    assign w_rem_fix   = r_neg_rem ? -r_acc : r_acc;

    assign busy        = (r_state != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_q         <= '0;
            r_b         <= '0;
            r_is_div    <= 1'b0;
            r_neg_res   <= 1'b0;
            r_neg_rem   <= 1'b0;
            r_zero_div  <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            HI          <= '0;
            LO          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if (flush) begin
                r_state <= StIdle;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (start) begin
                            case (op)
                                3'd0, 3'd1, 3'd2, 3'd3: begin
                                    r_acc      <= '0;
                                    r_q        <= w_a_mag;
                                    r_b        <= w_b_mag;
                                    r_is_div   <= op[1];
                                    r_neg_res  <= w_a_neg ^ w_b_neg;
                                    r_neg_rem  <= w_a_neg;
                                    r_zero_div <= (srcB == '0);
                                    r_cnt      <= '0;
                                    r_state    <= StRun;
                                end
                                3'd4: begin
                                    HI   <= srcA;
                                    done <= 1'b1;
                                end
                                3'd5: begin
                                    LO   <= srcA;
                                    done <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    StRun: begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_is_div) begin
                            // Restoring step: keep the trial difference only if it did not borrow.
                            if (!w_diff[WIDTH]) begin
                                r_acc <= w_diff[WIDTH-1:0];
                                r_q   <= {r_q[WIDTH-2:0], 1'b1};
                            end else begin
                                r_acc <= w_rem_sh[WIDTH-1:0];
                                r_q   <= {r_q[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            {r_acc, r_q} <= {w_mul_sum, r_q[WIDTH-1:1]};
                        end
                        if (r_cnt == CW'(WIDTH - 1)) begin
                            r_state <= StFix;
                        end
                    end
                    StFix: begin
                        if (r_is_div) begin
                            HI <= w_rem_fix;
                            LO <= w_quo_fix;
                        end else begin
                            {HI, LO} <= w_prod_fix;
                        end
                        done        <= 1'b1;
                        div_by_zero <= r_is_div & r_zero_div;
                        r_state     <= StIdle;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed HI/LO results.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op    = 3'd0;
    logic [W-1:0] srcA  = '0;
    logic [W-1:0] srcB  = '0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] HI;
    logic [W-1:0] LO;

    int n_tests = 0;
    int n_fail  = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .srcA        (srcA),
        .srcB        (srcB),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .HI          (HI),
        .LO          (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference arithmetic straight from the operation definitions.
    function automatic void model_calc(input logic [2:0] o, input logic [W-1:0] a,
                                       input logic [W-1:0] b, output logic [W-1:0] hi,
                                       output logic [W-1:0] lo, output logic dz);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        dz = 1'b0;
        hi = '0;
        lo = '0;
        sa = a;
        sb = b;
        case (o)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                hi = sp[63:32];
                lo = sp[31:0];
            end
            3'd1: begin
                up = {32'b0, a} * {32'b0, b};
                hi = up[63:32];
                lo = up[31:0];
            end
            default: begin
                if (b == '0) begin
                    hi = a;
                    lo = '1;
                    dz = 1'b1;
                end else if (o == 3'd2) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        lo = a;
                        hi = '0;
                    end else begin
                        lo = sa / sb;
                        hi = sa % sb;
                    end
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
    logic         m_done, m_dbz, p_dbz;
    int           m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi = '0; m_lo = '0; m_done = 1'b0; m_dbz = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            m_dbz  = 1'b0;
            if (flush) begin
                m_left = 0;
            end else if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_dbz = p_dbz;
                end
            end else if (start) begin
                if (op <= 3'd3) begin
                    model_calc(op, srcA, srcB, p_hi, p_lo, p_dbz);
                    m_left = W + 1;
                end else if (op == 3'd4) begin
                    m_hi = srcA; m_done = 1'b1;
                end else if (op == 3'd5) begin
                    m_lo = srcA; m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_busy", busy, m_left > 0);
        check("cyc_done", done, m_done);
        check("cyc_dbz", div_by_zero, m_dbz);
        check("cyc_hi", HI, m_hi);
        check("cyc_lo", LO, m_lo);
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit now);
        if (!now) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1; op = o; srcA = a; srcB = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bc, output bit got);
        lat = 0; bc = 0; got = 1'b0;
        while (!got && lat < 60) begin
            @(negedge clk);
            if (busy === 1'b1) bc++;
            if (done === 1'b1) got = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
    endtask

    task automatic run(input string nm, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                       input bit edz, input bit now);
        int lat, bc;
        bit got;
        issue(o, a, b, now);
        wait_done(lat, bc, got);
        check({nm, "_done"}, got, 1'b1);
        check({nm, "_lat"}, lat, W + 1);
        check({nm, "_busy"}, bc, W + 1);
        check({nm, "_hi"}, HI, ehi);
        check({nm, "_lo"}, LO, elo);
        check({nm, "_dbz"}, div_by_zero, edz);
        check({nm, "_model"}, {m_hi, m_lo}, {ehi, elo});
    endtask

    initial begin
        int dn;
        #1 rst_n = 1'b0;
        #2;
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        #10 rst_n = 1'b1;

        run("mult_neg",  3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 0);
        run("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
        run("mult_m1",   3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0, 1);
        run("div_neg",   3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
        run("divu_7_2",  3'd3, 32'd7,         32'd2,         32'd1,         32'd3,         0, 0);
        run("div_min",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 0);
        run("divu_z",    3'd3, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 1, 0);
        run("div_z",     3'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1, 0);
        run("div_negb",  3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 0, 0);

        issue(3'd5, 32'h1234_5678, 32'd0, 0);
        @(negedge clk);
        check("mtlo_done", done, 1);
        check("mtlo_lo", LO, 32'h1234_5678);
        check("mtlo_busy", busy, 0);
        @(negedge clk);
        check("mtlo_done_off", done, 0);

        issue(3'd4, 32'hCAFE_F00D, 32'd0, 0);
        @(negedge clk);
        check("mthi_done", done, 1);
        check("mthi_hi", HI, 32'hCAFE_F00D);
        check("mthi_busy", busy, 0);

        issue(3'd6, 32'hDEAD_BEEF, 32'd1, 0);
        @(negedge clk);
        check("rsvd_done", done, 0);
        check("rsvd_busy", busy, 0);
        check("rsvd_hilo", {HI, LO}, {32'hCAFE_F00D, 32'h1234_5678});

        @(posedge clk);
        #1 start = 1'b1; op = 3'd5; srcA = 32'hDEAD_BEEF; flush = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_start_lo", LO, 32'h1234_5678);
        check("flush_start_done", done, 0);

        begin
            int lat, bc;
            bit got;
            issue(3'd0, 32'd6, 32'd7, 0);
            repeat (5) @(posedge clk);
            #1 start = 1'b1; op = 3'd3; srcA = 32'd100; srcB = 32'd3;
            @(posedge clk);
            #1 start = 1'b0;
            wait_done(lat, bc, got);
            check("ign_done", got, 1);
            check("ign_hilo", {HI, LO}, {32'd0, 32'd42});
        end

        issue(3'd0, 32'd3, 32'd3, 0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        check("flush_nodone", dn, 0);
        check("flush_busy", busy, 0);
        check("flush_hilo", {HI, LO}, {32'd0, 32'd42});

        issue(3'd3, 32'd100, 32'd7, 0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_hi", HI, 0);
        check("arst_lo", LO, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_dbz", div_by_zero, 0);
        #3 rst_n = 1'b1;
        run("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit with architectural HI/LO registers. It sits beside the EX-stage ALU of the pipelined MIPS core, and its LO (and HI) outputs feed the ALU's LO pass-through path (MFLO/MFHI). It executes signed and unsigned MULT/DIV in WIDTH-step shift-add / restoring iterations and handles MTHI/MTLO writes. A busy/done handshake lets the hazard unit stall the pipeline.

## Interface
Parameters:
- WIDTH, 32, operand, HI and LO width; must be ≥ 4.
- CW, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only when busy=0.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 reserved.
- srcA  in  WIDTH  multiplicand / dividend / MTHI-MTLO data.
- srcB  in  WIDTH  multiplier / divisor.
- flush  in  1  aborts any in-flight MULT/DIV.
- busy  out  1  MULT/DIV in progress.
- done  out  1  one-cycle pulse when HI/LO have just been updated.
- div_by_zero  out  1  pulses with done for a DIV/DIVU whose divisor is 0.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 with op 0–3: latch operand magnitudes (|x| for signed ops, raw for unsigned), the result sign, the remainder sign (dividend sign), and the zero-divisor flag. Clear the counter and go to RUN.
  - start=1 with op 4/5: write srcA to HI/LO; state stays IDLE.
  - start=1 with op 6/7: ignored; no done.
- RUN: one iteration per cycle; counter increments. After the WIDTH-th iteration, go to FIX.
  - Multiply: 2·WIDTH-bit shift-add over the magnitudes.
  - Divide: restoring shift-subtract producing a WIDTH-bit quotient and a WIDTH-bit remainder.
- FIX: apply signs and write HI/LO, pulse done, go to IDLE.
  - MULT: {HI,LO} = 2·WIDTH-bit two's-complement negate of the product if the result sign is negative.
  - DIV: LO = quotient, negated if the operand signs differ. HI = remainder, negated if the dividend was negative.
  - MULTU/DIVU: no sign adjustment.
- Arithmetic rules:
  - MIN / −1 (signed): LO = MIN, HI = 0; no trap.
  - Divisor 0, any signedness: HI = srcA as presented, LO = all-ones, div_by_zero=1 for the done cycle. Latency is still full.
- flush=1: any state returns to IDLE on the next edge. busy drops; HI/LO unchanged; no done. flush overrides a simultaneous start.
- start while busy=1: ignored; operands are not re-latched.

## Timing
- Reset (asynchronous, rst_n=0): HI=0, LO=0, busy=0, done=0, div_by_zero=0, state IDLE, counter 0.
- Reset asserted mid-operation aborts it. HI/LO then read 0 and no done is produced.
- MULT/DIV, with start accepted at edge E0:
  - busy=1 from E0 to E0+WIDTH+1, i.e. WIDTH+1 cycles high.
  - HI/LO update and done=1 at edge E0+WIDTH+1; done is high for exactly that one cycle.
  - busy=0 in the done cycle, so a back-to-back start in that cycle is accepted.
- MTHI/MTLO accepted at E0: HI/LO update at E0 and done=1 for the following cycle. busy stays 0.
- HI/LO are stable except at update edges. Reads in the same cycle as an update see the old value.
- done and div_by_zero are registered outputs.

## Test plan
- MULT, srcA=−3 (FFFFFFFD), srcB=5, WIDTH=32 → HI=FFFFFFFF, LO=FFFFFFF1. done at edge E0+33; busy high for exactly 33 cycles.
- MULTU FFFFFFFF×FFFFFFFF → HI=FFFFFFFE, LO=00000001. MULT with the same operands → HI=0, LO=1.
- DIV −7/2 → LO=FFFFFFFD, HI=FFFFFFFF.
  - DIVU 7/2 → LO=3, HI=1.
  - DIV 80000000/FFFFFFFF → LO=80000000, HI=0.
- DIVU 7/0 → HI=7, LO=FFFFFFFF, div_by_zero=1 coincident with done, at full latency.
- MTLO 12345678 → LO=12345678 one edge later, done pulse, busy never high. Then:
  - Start MULT; pulse start with other operands mid-run → ignored.
  - A second MULT with flush at cycle 10 → HI/LO keep the first MULT's result and no done follows.
- Mid-RUN rst_n=0 (asynchronous, between edges) → all outputs 0 immediately. After release, a new DIVU 100/7 → LO=14, HI=2.
